// File: rtl/sample_framer.sv
// sample_framer
//
// Purpose:
//   Upstream framing stage for the FFT note-transcription path. Takes a
//   stream of 8-bit audio samples qualified by a valid strobe, keeps every
//   DECIM-th one, and writes exactly FFT_SIZE samples per frame into the FFT
//   core. Once a frame is full it pulses fft_start and holds off further
//   frames until the core signals completion on fft_done (or a watchdog
//   expires). Dropped samples, watchdog expiry and a completed-frame count
//   are reported for debug.
//
// Parameters:
//   N        - load index width, FFT_SIZE = 2**N
//   FFT_SIZE - samples per frame
//   DECIM    - accept every DECIM-th valid sample (DECIM >= 1)
//   TIMEOUT  - maximum number of WAIT cycles before giving up on fft_done
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   sample_valid in   one-cycle strobe qualifying sample_in
//   sample_in    in   8-bit audio sample
//   fft_done     in   completion level from the FFT core
//   fft_load     out  one-cycle write strobe to the FFT core
//   din          out  sample to the FFT core, valid while fft_load = 1
//   fft_start    out  one-cycle compute start pulse
//   load_idx     out  index of the next sample to load in the frame
//   busy         out  high while in START or WAIT
//   overrun      out  sticky: a sample arrived while busy
//   timeout_err  out  sticky: WAIT ran for TIMEOUT cycles without fft_done
//   frame_cnt    out  completed frames, wraps at 16 bits

module sample_framer #(
    parameter int N        = 9,
    parameter int FFT_SIZE = 512,
    parameter int DECIM    = 1,
    parameter int TIMEOUT  = 1048576
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [7:0]    sample_in,
    input  logic          fft_done,
    output logic          fft_load,
    output logic [7:0]    din,
    output logic          fft_start,
    output logic [N-1:0]  load_idx,
    output logic          busy,
    output logic          overrun,
    output logic          timeout_err,
    output logic [15:0]   frame_cnt
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DW-1:0] DECIM_LAST   = DW'(DECIM - 1);
    localparam logic [N-1:0]  IDX_LAST     = N'(FFT_SIZE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_WAIT
    } state_t;

    state_t         state;
    logic [DW-1:0]  decim_cnt;
    logic [TW-1:0]  timeout_cnt;
    logic           fft_done_q;
    logic           done_edge;

    // Only a rising edge of the done level counts as completion, so a core
    // that leaves fft_done high from an earlier frame cannot end the next
    // one early.
    assign done_edge = fft_done & ~fft_done_q;

    // Single controller: every output is a register updated here.
    //
    // FILL collects decimated samples and presents each accepted one on
    // din/fft_load one cycle later. The final sample of a frame moves to
    // START, which lasts two cycles: the first is the cycle carrying the
    // last fft_load, the second carries fft_start, so load and start never
    // overlap. WAIT then watches for a done edge, with a watchdog counter
    // as a fallback; a done edge arriving on the last watchdog cycle still
    // counts as a normal completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FILL;
            decim_cnt   <= '0;
            timeout_cnt <= '0;
            fft_done_q  <= 1'b0;
            fft_load    <= 1'b0;
            din         <= 8'd0;
            fft_start   <= 1'b0;
            load_idx    <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            fft_done_q <= fft_done;
            fft_load   <= 1'b0;
            fft_start  <= 1'b0;

            case (state)
                S_FILL: begin
                    if (sample_valid) begin
                        if (decim_cnt == DECIM_LAST) begin
                            decim_cnt <= '0;
                            fft_load  <= 1'b1;
                            din       <= sample_in;
                            if (load_idx == IDX_LAST) begin
                                load_idx <= '0;
                                state    <= S_START;
                                busy     <= 1'b1;
                            end else begin
                                load_idx <= load_idx + N'(1);
                            end
                        end else begin
                            decim_cnt <= decim_cnt + DW'(1);
                        end
                    end
                end

                S_START: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    // fft_start doubles as the marker for the second START
                    // cycle: raise it once, then move on to WAIT.
                    if (!fft_start) begin
                        fft_start <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    if (done_edge) begin
                        frame_cnt   <= frame_cnt + 16'd1;
                        state       <= S_FILL;
                        busy        <= 1'b0;
                        decim_cnt   <= '0;
                        timeout_cnt <= '0;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_FILL;
                        busy        <= 1'b0;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end

                default: begin
                    state <= S_FILL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
